data_mem_arbiter: RTL and testbench

- Two-port arbiter/sequencer in front of the single-port Data_mem.
- Port 0 is the core load/store unit; port 1 is the debug/DMA loader.
- Serialises their requests onto Data_mem's Data_address/Data_in/we/re/Data_out interface using round-robin priority.
- Drives we/re as one-cycle pulses, captures read data after the memory read latency, and returns a one-cycle ack per transaction.

---
 rtl/data_mem_arb_pkg.sv | 25 ++
 rtl/data_mem_arbiter_rr_pick2.sv | 29 ++
 rtl/data_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// ============================================================================
// Module      : data_mem_arb_pkg
// Description : Shared types and constants for the Data_mem two-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

`default_nettype wire

// File: rtl/data_mem_arbiter_rr_pick2.sv
// ============================================================================
// Module      : rr_pick2
// Description : Two-requester round-robin pick; on contention the port that
//               was not granted last wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2
    import data_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        case (req)
            2'b10:   gnt_id = PORT1;
            2'b11:   gnt_id = ~last_grant;
            default: gnt_id = PORT0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ============================================================================
// Module      : data_mem_arbiter
// Description : Serialises two request ports onto the single-port Data_mem
//               with round-robin priority and a one-cycle ack per transaction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              We0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] Wdata0,
    output logic              Ack0,
    output logic [DATA_W-1:0] Rdata0,
    input  logic              Req1,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] Wdata1,
    output logic              Ack1,
    output logic [DATA_W-1:0] Rdata1,
    output logic              Busy,
    output logic [ADDR_W-1:0] Mem_address,
    output logic [DATA_W-1:0] Mem_data_in,
    output logic              Mem_we,
    output logic              Mem_re,
    input  logic [DATA_W-1:0] Mem_data_out
);

    localparam int CNT_W = 2;

    arb_state_t        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_id_q, gnt_id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic pick_valid;
    logic pick_id;

    rr_pick2 u_pick (
        .req        ({Req1, Req0}),
        .last_grant (last_grant_q),
        .gnt_valid  (pick_valid),
        .gnt_id     (pick_id)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT1;
            gnt_id_q     <= PORT0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_id_d     = pick_id;
                    last_grant_d = pick_id;
                    we_d         = (pick_id == PORT1) ? We1    : We0;
                    addr_d       = (pick_id == PORT1) ? Addr1  : Addr0;
                    wdata_d      = (pick_id == PORT1) ? Wdata1 : Wdata0;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    // WAIT spans RD_LATENCY cycles so data is sampled once valid
                    state_d = WAIT;
                    cnt_d   = CNT_W'(RD_LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (gnt_id_q == PORT1) begin
                        rdata1_d = Mem_data_out;
                    end else begin
                        rdata0_d = Mem_data_out;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy        = (state_q != IDLE);
        Ack0        = (state_q == DONE) && (gnt_id_q == PORT0);
        Ack1        = (state_q == DONE) && (gnt_id_q == PORT1);
        Rdata0      = rdata0_q;
        Rdata1      = rdata1_q;
        Mem_we      = (state_q == ACCESS) && we_q;
        Mem_re      = (state_q == ACCESS) && !we_q;
        Mem_address = '0;
        Mem_data_in = '0;
        if ((state_q == ACCESS) || (state_q == WAIT)) begin
            Mem_address = addr_q;
            Mem_data_in = wdata_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Self-checking bench: two arbiters (read latency 1 and 3), each
//               in front of a behavioural Data_mem, against a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_data_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst  [2];
    logic [1:0]    req  [2];
    logic [1:0]    wen  [2];
    logic [AW-1:0] addr [2][2];
    logic [DW-1:0] wdat [2][2];
    wire  [1:0]    ack  [2];
    wire  [DW-1:0] rdat [2][2];
    wire           busy [2];
    wire  [AW-1:0] m_addr [2];
    wire  [DW-1:0] m_din  [2];
    wire           m_we [2];
    wire           m_re [2];

    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    logic [DW-1:0] ref_mem  [2][1024];
    logic          ref_last [2];

    for (genvar i = 0; i < 2; i++) begin : g_inst
        localparam int L = (i == 0) ? LAT0 : LAT1;
        logic [DW-1:0] mem  [1024];
        logic [DW-1:0] pipe [4];
        wire  [DW-1:0] dout = pipe[L-1];

        data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L)) u_dut (
            .Clk          (clk),
            .Reset        (rst[i]),
            .Req0         (req[i][0]),
            .We0          (wen[i][0]),
            .Addr0        (addr[i][0]),
            .Wdata0       (wdat[i][0]),
            .Ack0         (ack[i][0]),
            .Rdata0       (rdat[i][0]),
            .Req1         (req[i][1]),
            .We1          (wen[i][1]),
            .Addr1        (addr[i][1]),
            .Wdata1       (wdat[i][1]),
            .Ack1         (ack[i][1]),
            .Rdata1       (rdat[i][1]),
            .Busy         (busy[i]),
            .Mem_address  (m_addr[i]),
            .Mem_data_in  (m_din[i]),
            .Mem_we       (m_we[i]),
            .Mem_re       (m_re[i]),
            .Mem_data_out (dout)
        );

        // Data_mem model: data valid L cycles after the re cycle, garbage otherwise
        initial for (int j = 0; j < 1024; j++) mem[j] = '0;
        always @(posedge clk) begin
            pipe[0] <= m_re[i] ? mem[m_addr[i][11:2]] : $urandom;
            for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
            if (m_we[i]) mem[m_addr[i][11:2]] = m_din[i];
        end
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    // Round robin: lone requester wins; on contention the one not served last
    function automatic int pick(input logic [1:0] m, input logic last);
        if (m == 2'b11) return last ? 0 : 1;
        return m[1] ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_port(input int k, input int p);
        wen[k][p]  = 1'($urandom_range(0, 1));
        addr[k][p] = 32'($urandom_range(0, 1023)) << 2;
        wdat[k][p] = $urandom;
    endtask

    task automatic set_port(input int k, input int p, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        wen[k][p]  = w;
        addr[k][p] = a;
        wdat[k][p] = d;
    endtask

    task automatic chk_reset_outs(input int k);
        chk("rst_ack_busy_we_re", {ack[k], busy[k], m_we[k], m_re[k]}, '0);
        chk("rst_rdata", {rdat[k][0], rdat[k][1]}, '0);
        chk("rst_mem_bus", {m_addr[k], m_din[k]}, '0);
    endtask

    // Hold requests in mask until ntx acks; called with the DUT idle, #1 after an edge
    task automatic run_txns(input int k, input logic [1:0] mask, input int ntx,
                            input bit drop_early, input bit rerand);
        int n, done_cnt, p, exp_access, exp_ack, quiet, ops;
        n = 0; done_cnt = 0; quiet = 0; ops = 0;
        req[k] = mask;
        p = pick(mask, ref_last[k]);
        exp_access = 1;
        exp_ack = 2 + (wen[k][p] ? 0 : lat_of(k));
        while (quiet < 8 && n < 400) begin
            tick();
            n++;
            if (drop_early && n == 1) req[k] = 2'b00;
            if (m_we[k] || m_re[k]) begin
                ops++;
                chk("op_cycle", n, (done_cnt < ntx) ? exp_access : 0);
                chk("op_type", {m_we[k], m_re[k]}, {wen[k][p], ~wen[k][p]});
                chk("op_addr", m_addr[k], addr[k][p]);
                if (wen[k][p]) chk("op_wdata", m_din[k], wdat[k][p]);
            end
            if (ack[k] != 2'b00) begin
                chk("ack_port", ack[k], (done_cnt < ntx) ? (2'b01 << p) : 2'b00);
                chk("ack_cycle", n, exp_ack);
                chk("ops_per_txn", ops, 1);
                ops = 0;
                if (done_cnt < ntx) begin
                    if (wen[k][p]) ref_mem[k][addr[k][p][11:2]] = wdat[k][p];
                    else chk("rdata", rdat[k][p], ref_mem[k][addr[k][p][11:2]]);
                    ref_last[k] = p[0];
                    done_cnt++;
                    if (done_cnt == ntx) begin
                        req[k] = 2'b00;
                    end else begin
                        if (rerand) rand_port(k, p);
                        p = pick(req[k], ref_last[k]);
                        exp_access = n + 2;
                        exp_ack = exp_access + 1 + (wen[k][p] ? 0 : lat_of(k));
                    end
                end
            end
            if (done_cnt == ntx) quiet++;
        end
        chk("txn_count", done_cnt, ntx);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("we_re_exclusive", m_we[k] & m_re[k], 1'b0);
                chk("acks_exclusive", ack[k] == 2'b11, 1'b0);
                if (!busy[k]) chk("idle_mem_quiet", {m_addr[k], m_din[k], m_we[k], m_re[k]}, '0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            req[k] = 2'b11;
            ref_last[k] = 1'b1;
            for (int p = 0; p < 2; p++) set_port(k, p, 1'b0, 32'd1024 + 32'(4 * p), '0);
            for (int j = 0; j < 1024; j++) ref_mem[k][j] = '0;
        end

        // Reset held two cycles with both requests up
        repeat (2) begin
            tick();
            for (int k = 0; k < 2; k++) chk_reset_outs(k);
        end
        mon_en = 1'b1;
        req[1] = 2'b00;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk("post_rst_idle", {busy[0], m_we[0], m_re[0]}, 3'b000);
        run_txns(0, 2'b11, 2, 1'b0, 1'b0);

        // Port 0 write then read-back
        set_port(0, 0, 1'b1, 32'd1024, 32'hFFFF_FFFF);
        run_txns(0, 2'b01, 1, 1'b0, 1'b0);
        set_port(0, 0, 1'b0, 32'd1024, '0);
        run_txns(0, 2'b01, 1, 1'b0, 1'b0);
        chk("rdata0_ffff", rdat[0][0], 32'hFFFF_FFFF);

        // Sustained read contention
        set_port(0, 0, 1'b0, 32'd1024, '0);
        set_port(0, 1, 1'b0, 32'd1028, '0);
        run_txns(0, 2'b11, 4, 1'b0, 1'b0);

        // Port 1 write and port 0 read of the same word in one IDLE cycle
        set_port(0, 1, 1'b1, 32'd1028, 32'h1234_5678);
        set_port(0, 0, 1'b0, 32'd1028, '0);
        run_txns(0, 2'b11, 2, 1'b0, 1'b0);
        chk("rdata0_1234", rdat[0][0], 32'h1234_5678);

        // Port 1 drops its request right after grant
        set_port(0, 1, 1'b0, 32'd1028, '0);
        run_txns(0, 2'b10, 1, 1'b1, 1'b0);

        // Latency-3 instance: prime 1024, then abort a read in WAIT
        set_port(1, 0, 1'b1, 32'd1024, 32'hFFFF_FFFF);
        run_txns(1, 2'b01, 1, 1'b0, 1'b0);
        set_port(1, 0, 1'b0, 32'd1024, '0);
        run_txns(1, 2'b01, 1, 1'b0, 1'b0);
        req[1] = 2'b01;
        tick();
        chk("abort_access_re", {m_we[1], m_re[1]}, 2'b01);
        req[1] = 2'b00;
        tick();
        chk("abort_in_wait", {busy[1], m_we[1], m_re[1]}, 3'b100);
        rst[1] = 1'b1;
        tick();
        chk_reset_outs(1);
        rst[1] = 1'b0;
        ref_last[1] = 1'b1;
        acks = 0;
        repeat (6) begin
            tick();
            if (ack[1] != 2'b00) acks++;
        end
        chk("abort_no_ack", acks, 0);
        chk("abort_rdata_cleared", rdat[1][0], '0);
        run_txns(1, 2'b01, 1, 1'b0, 1'b0);
        chk("reread_after_abort", rdat[1][0], 32'hFFFF_FFFF);

        // Randomised traffic on both instances
        for (int r = 0; r < 40; r++) begin
            int k, ntx;
            logic [1:0] mask;
            k = $urandom_range(0, 1);
            mask = 2'($urandom_range(1, 3));
            ntx = $urandom_range(1, 4);
            rand_port(k, 0);
            rand_port(k, 1);
            run_txns(k, mask, ntx, (ntx == 1) && ($urandom_range(0, 3) == 0), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
